// File: rtl/inst_fetch_unit.sv
// Fetch stage: issues sequential 16-bit fetches under a credit limit, queues the
// returned words with their PC, and on redirect flushes and drops the stale stream.
module inst_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                IQ_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [15:0]       imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  output logic              inst_valid,
  output logic [15:0]       inst,
  output logic [ADDR_W-1:0] inst_pc
);
  localparam int PW = $clog2(IQ_DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [15:0]       r_q_inst [IQ_DEPTH];
  logic [ADDR_W-1:0] r_q_pc   [IQ_DEPTH];
  logic [ADDR_W-1:0] r_pp     [IQ_DEPTH];
  logic [PW-1:0]     r_q_rd, r_q_wr, r_pp_rd, r_pp_wr;
  logic [CW-1:0]     r_q_cnt, r_out, r_drop;
  logic [15:0]       r_last_inst;
  logic [ADDR_W-1:0] r_last_pc;

  logic [CW:0]       w_used;
  logic              w_credit, w_accept, w_rsp, w_keep, w_pop;
  logic [ADDR_W-1:0] w_redir_pc;

  // Slots committed to the live stream: queued words plus requests still owed a reply.
  assign w_used     = {1'b0, r_q_cnt} + {1'b0, r_out} - {1'b0, r_drop};
  assign w_credit   = w_used < (CW+1)'(IQ_DEPTH);
  assign w_redir_pc = redirect_pc & ~ADDR_W'(1);

  assign imem_req_valid = w_credit && !redirect_valid && !reset;
  assign imem_addr      = r_fetch_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;
  assign w_rsp          = imem_rsp_valid && (r_out != '0);
  assign w_keep         = w_rsp && (r_drop == '0);

  assign inst_valid = (r_q_cnt != '0);
  assign inst       = inst_valid ? r_q_inst[r_q_rd] : r_last_inst;
  assign inst_pc    = inst_valid ? r_q_pc[r_q_rd]   : r_last_pc;
  assign w_pop      = inst_valid && !stall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fetch_pc  <= RESET_PC;
      r_q_rd      <= '0;
      r_q_wr      <= '0;
      r_pp_rd     <= '0;
      r_pp_wr     <= '0;
      r_q_cnt     <= '0;
      r_out       <= '0;
      r_drop      <= '0;
      r_last_inst <= '0;
      r_last_pc   <= '0;
      for (int i = 0; i < IQ_DEPTH; i++) begin
        r_q_inst[i] <= '0;
        r_q_pc[i]   <= '0;
        r_pp[i]     <= '0;
      end
    end else begin
      if (r_q_cnt != '0) begin
        r_last_inst <= r_q_inst[r_q_rd];
        r_last_pc   <= r_q_pc[r_q_rd];
      end
      if (redirect_valid) begin
        // Everything still owed by memory belongs to the abandoned stream.
        r_fetch_pc <= w_redir_pc;
        r_q_rd     <= '0;
        r_q_wr     <= '0;
        r_q_cnt    <= '0;
        r_pp_rd    <= '0;
        r_pp_wr    <= '0;
        r_out      <= r_out - CW'(w_rsp);
        r_drop     <= r_out - CW'(w_rsp);
      end else begin
        if (w_accept) begin
          r_fetch_pc       <= r_fetch_pc + ADDR_W'(2);
          r_pp[r_pp_wr]    <= r_fetch_pc;
          r_pp_wr          <= r_pp_wr + PW'(1);
        end
        r_out <= r_out + CW'(w_accept) - CW'(w_rsp);
        if (w_rsp && (r_drop != '0))
          r_drop <= r_drop - CW'(1);
        if (w_keep) begin
          r_q_inst[r_q_wr] <= imem_rsp_data;
          r_q_pc[r_q_wr]   <= r_pp[r_pp_rd];
          r_q_wr           <= r_q_wr + PW'(1);
          r_pp_rd          <= r_pp_rd + PW'(1);
        end
        if (w_pop)
          r_q_rd <= r_q_rd + PW'(1);
        r_q_cnt <= r_q_cnt + CW'(w_keep) - CW'(w_pop);
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: in-order memory model with programmable latency and a
// scoreboard of expected {pc, word} pairs pushed at request acceptance.
module tb_inst_fetch_unit;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        redirect_valid, stall, inst_valid;
  logic [15:0] imem_addr, imem_rsp_data, redirect_pc, inst, inst_pc;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int lat    = 1;

  logic [15:0] mem_addr_q[$];
  int          mem_due_q[$];
  logic [31:0] exp_q[$];
  logic [15:0] exp_pc;
  logic [15:0] pop_pc_q[$];
  logic [15:0] pop_inst_q[$];

  always #5 clock = ~clock;

  inst_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000), .IQ_DEPTH(2)) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc)
  );

  function automatic logic [15:0] mem(input logic [15:0] a);
    case (a)
      16'h0000: mem = 16'h9696;
      16'h0002: mem = 16'h1234;
      16'h0004: mem = 16'hABCD;
      default:  mem = a ^ 16'hC3A5;
    endcase
  endfunction

  // One clock cycle: observe the handshakes the coming edge will take, then drive responses.
  task automatic step();
    logic [31:0] e;
    @(negedge clock);
    if (!reset) begin
      if (redirect_valid) begin
        checks++;
        if (imem_req_valid !== 1'b0) begin
          errors++; $display("FAIL redir_no_req: req_valid=%b required 0", imem_req_valid);
        end
        exp_q.delete();
        exp_pc = {redirect_pc[15:1], 1'b0};
      end else begin
        if (exp_q.size() >= 2) begin
          checks++;
          if (imem_req_valid !== 1'b0 || exp_q.size() > 2) begin
            errors++; $display("FAIL credit: req_valid=%b inflight=%0d required 0 and <=2", imem_req_valid, exp_q.size());
          end
        end
        if (inst_valid && !stall) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL spurious_inst: inst=%h pc=%h nothing expected", inst, inst_pc);
          end else begin
            e = exp_q.pop_front();
            if ({inst_pc, inst} !== e) begin
              errors++; $display("FAIL inst_out: pc/inst=%h/%h required %h/%h", inst_pc, inst, e[31:16], e[15:0]);
            end
          end
          pop_pc_q.push_back(inst_pc);
          pop_inst_q.push_back(inst);
        end
        if (imem_req_valid && imem_req_ready) begin
          checks++;
          if (imem_addr !== exp_pc) begin
            errors++; $display("FAIL req_addr: addr=%h required %h", imem_addr, exp_pc);
          end
          exp_q.push_back({exp_pc, mem(exp_pc)});
          mem_addr_q.push_back(imem_addr);
          mem_due_q.push_back(cyc + lat);
          exp_pc = exp_pc + 16'd2;
        end
      end
    end
    @(posedge clock);
    #1;
    cyc++;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 16'hDEAD;
    if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 16'h0;
    redirect_valid = 1'b0; redirect_pc = 16'h0; stall = 1'b0;
    exp_pc = 16'h0000;
    for (int i = 0; i < 5; i++) step();
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: %b required 0", imem_req_valid); end
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL rst_addr: %h required 0000", imem_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid: %b required 0", inst_valid); end
    checks++; if (inst !== 16'h0000) begin errors++; $display("FAIL rst_inst: %h required 0000", inst); end
    checks++; if (inst_pc !== 16'h0000) begin errors++; $display("FAIL rst_inst_pc: %h required 0000", inst_pc); end
    reset = 1'b0;
    #2;
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL first_req: req_valid=%b required 1", imem_req_valid); end
    step();
  endtask

  task automatic test_streaming();
    lat = 1; imem_req_ready = 1'b1; stall = 1'b0;
    pop_pc_q.delete(); pop_inst_q.delete();
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (pop_pc_q.size() < 3) begin
      errors++; $display("FAIL stream_count: pops=%0d required >=3", pop_pc_q.size());
    end else if (pop_pc_q[0] !== 16'h0000 || pop_inst_q[0] !== 16'h9696 ||
                 pop_pc_q[1] !== 16'h0002 || pop_inst_q[1] !== 16'h1234 ||
                 pop_pc_q[2] !== 16'h0004 || pop_inst_q[2] !== 16'hABCD) begin
      errors++; $display("FAIL stream_order: %h/%h %h/%h %h/%h required 0000/9696 0002/1234 0004/abcd",
                         pop_pc_q[0], pop_inst_q[0], pop_pc_q[1], pop_inst_q[1], pop_pc_q[2], pop_inst_q[2]);
    end
  endtask

  task automatic drain(input string tag);
    imem_req_ready = 1'b0; stall = 1'b0;
    for (int i = 0; i < 30 && (exp_q.size() > 0 || mem_addr_q.size() > 0); i++) step();
    checks++;
    if (exp_q.size() != 0 || mem_addr_q.size() != 0) begin
      errors++; $display("FAIL drain_%s: left=%0d owed=%0d required 0", tag, exp_q.size(), mem_addr_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] head;
    int          owed;
    lat = 1; imem_req_ready = 1'b1; stall = 1'b0;
    for (int i = 0; i < 3; i++) step();
    stall = 1'b1;
    step();
    step();
    head = {inst_pc, inst};
    owed = mem_addr_q.size();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({inst_pc, inst} !== head || inst_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold: valid=%b pc/inst=%h/%h required 1 %h/%h", inst_valid, inst_pc, inst, head[31:16], head[15:0]);
      end
    end
    checks++;
    if (exp_q.size() > 2 || mem_addr_q.size() > owed) begin
      errors++; $display("FAIL stall_credit: inflight=%0d owed=%0d required <=2 and <=%0d", exp_q.size(), mem_addr_q.size(), owed);
    end
    stall = 1'b0;
    for (int i = 0; i < 10; i++) step();
    drain("bp");
  endtask

  task automatic test_redirect();
    lat = 3; imem_req_ready = 1'b1; stall = 1'b0;
    for (int i = 0; i < 10 && mem_addr_q.size() < 2; i++) step();
    checks++;
    if (mem_addr_q.size() != 2) begin
      errors++; $display("FAIL redir_setup: owed=%0d required 2", mem_addr_q.size());
    end
    pop_pc_q.delete(); pop_inst_q.delete();
    redirect_valid = 1'b1; redirect_pc = 16'h0041;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (inst_valid !== 1'b0) begin
        errors++; $display("FAIL redir_quiet: inst_valid=%b pc=%h cycle+%0d required 0", inst_valid, inst_pc, i + 1);
      end
      step();
    end
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (pop_pc_q.size() < 2 || pop_pc_q[0] !== 16'h0040 || pop_pc_q[1] !== 16'h0042) begin
      errors++; $display("FAIL redir_target: pops=%0d first=%h required 0040,0042", pop_pc_q.size(),
                         (pop_pc_q.size() > 0) ? pop_pc_q[0] : 16'hFFFF);
    end
    drain("redir");
  endtask

  task automatic test_wrap();
    lat = 1; imem_req_ready = 1'b1; stall = 1'b0;
    pop_pc_q.delete(); pop_inst_q.delete();
    redirect_valid = 1'b1; redirect_pc = 16'hFFFC;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (pop_pc_q.size() < 4 || pop_pc_q[0] !== 16'hFFFC || pop_pc_q[1] !== 16'hFFFE ||
        pop_pc_q[2] !== 16'h0000 || pop_pc_q[3] !== 16'h0002) begin
      errors++; $display("FAIL wrap_pcs: pops=%0d required fffc,fffe,0000,0002", pop_pc_q.size());
    end
    drain("wrap");
  endtask

  task automatic test_reset_mid();
    lat = 3; imem_req_ready = 1'b1; stall = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 16'h0100;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 10 && mem_addr_q.size() < 2; i++) step();
    checks++;
    if (mem_addr_q.size() != 2) begin
      errors++; $display("FAIL rmid_setup: owed=%0d required 2", mem_addr_q.size());
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0 || imem_addr !== 16'h0000 ||
        inst !== 16'h0000 || inst_pc !== 16'h0000) begin
      errors++; $display("FAIL rmid_async: valid=%b req=%b addr=%h inst=%h pc=%h required all 0",
                         inst_valid, imem_req_valid, imem_addr, inst, inst_pc);
    end
    exp_q.delete(); exp_pc = 16'h0000;
    imem_req_ready = 1'b0; stall = 1'b0;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (inst_valid !== 1'b0) begin
        errors++; $display("FAIL rmid_late_rsp: inst_valid=%b pc=%h required 0", inst_valid, inst_pc);
      end
    end
    checks++;
    if (mem_addr_q.size() != 0) begin
      errors++; $display("FAIL rmid_owed: %0d required 0", mem_addr_q.size());
    end
    pop_pc_q.delete(); pop_inst_q.delete();
    lat = 1; imem_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (pop_pc_q.size() < 1 || pop_pc_q[0] !== 16'h0000 || pop_inst_q[0] !== 16'h9696) begin
      errors++; $display("FAIL rmid_resume: pops=%0d required first 0000/9696", pop_pc_q.size());
    end
    drain("rmid");
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
